// File: rtl/st_irq_pkg.sv
// Shared types and default interrupt levels for the ST interrupt arbiter.
package st_irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_MFP  = 2'd1,
    ACK_AUTO = 2'd2,
    ACK_SPUR = 2'd3
  } irq_state_t;

  localparam logic [2:0]  MFP_LEVEL_DEF   = 3'd6;
  localparam logic [2:0]  VBL_LEVEL_DEF   = 3'd4;
  localparam logic [2:0]  HBL_LEVEL_DEF   = 3'd2;
  localparam int unsigned ACK_TIMEOUT_DEF = 32;

endpackage

// File: rtl/st_irq_arbiter.sv
// Interrupt priority encoder and acknowledge sequencer for the MFP, VBL and HBL
// sources: drives the CPU IPL lines and steers each IACK cycle to MFP vector,
// autovector or spurious.
module st_irq_arbiter
  import st_irq_pkg::*;
#(
  parameter logic [2:0]  MFP_LEVEL   = MFP_LEVEL_DEF,
  parameter logic [2:0]  VBL_LEVEL   = VBL_LEVEL_DEF,
  parameter logic [2:0]  HBL_LEVEL   = HBL_LEVEL_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mfp_irq,
  input  logic       vbl,
  input  logic       hbl,
  input  logic       iack_start,
  input  logic [2:0] iack_level,
  input  logic       iack_end,
  output logic [2:0] ipl_n,
  output logic       mfp_iack,
  output logic       avec,
  output logic       spurious,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  irq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             vbl_q, hbl_q;
  logic             vbl_pend, hbl_pend;
  logic             vbl_clr, hbl_clr;
  logic             vbl_rise, hbl_rise;
  logic [2:0]       level;

  assign vbl_rise = vbl & ~vbl_q;
  assign hbl_rise = hbl & ~hbl_q;

  // Delay copies keep loading during reset so a level already high at release is not an edge.
  always_ff @(posedge clk) begin
    vbl_q <= vbl;
    hbl_q <= hbl;
  end

  // Highest active source level; MFP is level-sensitive and never latched.
  always_comb begin
    level = 3'd0;
    if (hbl_pend && (HBL_LEVEL > level)) level = HBL_LEVEL;
    if (vbl_pend && (VBL_LEVEL > level)) level = VBL_LEVEL;
    if (mfp_irq  && (MFP_LEVEL > level)) level = MFP_LEVEL;
  end

  // Acknowledge sequencing: next state, timeout counter and pending-bit clears.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    vbl_clr    = 1'b0;
    hbl_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iack_start) begin
          if ((iack_level == MFP_LEVEL) && mfp_irq) begin
            state_next = ACK_MFP;
          end else if ((iack_level == VBL_LEVEL) && vbl_pend) begin
            state_next = ACK_AUTO;
            vbl_clr    = 1'b1;
          end else if ((iack_level == HBL_LEVEL) && hbl_pend) begin
            state_next = ACK_AUTO;
            hbl_clr    = 1'b1;
          end else begin
            state_next = ACK_SPUR;
          end
        end
      end
      ACK_MFP: begin
        if (iack_end) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_next = ACK_SPUR;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ACK_AUTO, ACK_SPUR: begin
        if (iack_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      vbl_pend <= 1'b0;
      hbl_pend <= 1'b0;
      ipl_n    <= 3'b111;
      mfp_iack <= 1'b0;
      avec     <= 1'b0;
      spurious <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      // A fresh edge in the same cycle as an accepted ack keeps the bit set.
      vbl_pend <= vbl_rise | (vbl_pend & ~vbl_clr);
      hbl_pend <= hbl_rise | (hbl_pend & ~hbl_clr);
      if (state == IDLE) ipl_n <= ~level;
      mfp_iack <= (state_next == ACK_MFP);
      avec     <= (state_next == ACK_AUTO);
      spurious <= (state_next == ACK_SPUR);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/st_irq_arbiter.md
ST_IRQ_ARBITER -- requirements
Module: st_irq_arbiter

Interface
REQ-001 SHALL have parameter MFP_LEVEL, default 3'd6, CPU interrupt level of the MFP irq.
REQ-002 SHALL have parameter VBL_LEVEL, default 3'd4, level of the vertical blank source.
REQ-003 SHALL have parameter HBL_LEVEL, default 3'd2, level of the horizontal blank source.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 32, clk cycles allowed for an MFP vector cycle.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mfp_irq  in  1  MFP interrupt request, level-sensitive, active-high.
REQ-008 vbl  in  1  vertical blank, rising edge = event.
REQ-009 hbl  in  1  horizontal blank, rising edge = event.
REQ-010 iack_start  in  1  one-cycle pulse, CPU begins interrupt-acknowledge cycle.
REQ-011 iack_level  in  3  level being acknowledged, valid with iack_start.
REQ-012 iack_end  in  1  one-cycle pulse, CPU ends the acknowledge cycle.
REQ-013 ipl_n  out  3  encoded priority level to CPU, active-low.
REQ-014 mfp_iack  out  1  routes acknowledge to MFP (vector from MFP).
REQ-015 avec  out  1  autovector request to CPU.
REQ-016 spurious  out  1  spurious-interrupt / bus-error request to CPU.
REQ-017 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 vbl/hbl rising edge (input high, one-cycle-delayed copy low) SHALL set vbl_pend/hbl_pend.
REQ-019 Pending bit SHALL clear on acceptance of an ack at its level; a same-cycle new edge SHALL win (bit stays set).
REQ-020 Active level = highest of {MFP_LEVEL if mfp_irq, VBL_LEVEL if vbl_pend, HBL_LEVEL if hbl_pend}, 0 if none; ipl_n = ~level, registered, 1-cycle latency.
REQ-021 ipl_n SHALL be frozen while busy and resume tracking the cycle after return to IDLE.
REQ-022 FSM states: IDLE, ACK_MFP, ACK_AUTO, ACK_SPUR.
REQ-023 IDLE + iack_start: iack_level==MFP_LEVEL and mfp_irq -> ACK_MFP; ==VBL_LEVEL and vbl_pend -> ACK_AUTO, clear vbl_pend; ==HBL_LEVEL and hbl_pend -> ACK_AUTO, clear hbl_pend; otherwise -> ACK_SPUR.
REQ-024 Outputs SHALL be registered state decodes: mfp_iack=ACK_MFP, avec=ACK_AUTO, spurious=ACK_SPUR; asserted the cycle after iack_start.
REQ-025 ACK_MFP, ACK_AUTO, ACK_SPUR SHALL return to IDLE on iack_end.
REQ-026 ACK_MFP SHALL run a counter from 0; at ACK_TIMEOUT-1 without iack_end -> ACK_SPUR (counter cleared).
REQ-027 iack_start outside IDLE and iack_end in IDLE SHALL be ignored.
REQ-028 iack_start and iack_end same cycle in IDLE: iack_start processed, iack_end ignored.
REQ-029 MFP not latched; mfp_irq falling before iack_start SHALL make that ack spurious.

Reset
REQ-030 Reset SHALL force IDLE, vbl_pend=hbl_pend=0, counter 0, ipl_n=3'b111, mfp_iack=avec=spurious=busy=0.
REQ-031 During reset edge-delay registers SHALL load current vbl/hbl so an input high at release creates no event.
REQ-032 Reset mid-acknowledge SHALL abort the cycle with no pending-bit change beyond REQ-030.

Structure
REQ-033 Shared package st_irq_pkg SHALL hold FSM state enum and default level constants.
REQ-034 No sub-module required; edge detectors and timeout counter inline.

Verification
REQ-035 vbl pulse, iack_start level 4 -> ipl_n 3'b011 one cycle after pend; avec=1 next cycle; vbl_pend=0; iack_end -> IDLE.
REQ-036 mfp_irq=1 and hbl_pend=1, iack_start level 6 -> ipl_n 3'b001, mfp_iack=1 until iack_end; hbl_pend still 1, ipl_n 3'b101 after.
REQ-037 mfp_irq=1, iack_start level 6, no iack_end -> mfp_iack for 32 cycles, then spurious=1 until iack_end.
REQ-038 No pending, iack_start level 5 -> spurious=1 next cycle, ipl_n stays 3'b111.
REQ-039 vbl rising edge same cycle as accepted level-4 ack -> vbl_pend=1 after; second ack at level 4 gives avec.
REQ-040 vbl held high through reset release -> no pend, ipl_n 3'b111; reset asserted in ACK_AUTO -> all outputs 0 next cycle.
